// File: rtl/load_store_drain_pkg.sv
// Shared types and defaults for the load/store volume pair.
// Drain side of the benchmark: state codes and default sizing.
package load_store_drain_pkg;
  localparam int DEF_N     = 17500;
  localparam int DEF_CBITS = 15;

  typedef logic [1:0] drain_state_t;

  localparam drain_state_t S_IDLE  = 2'd0;
  localparam drain_state_t S_DRAIN = 2'd1;
  localparam drain_state_t S_DONE  = 2'd2;
endpackage

// File: rtl/load_store_drain_if.sv
// Downstream valid/ready channel carrying the remaining volume.
// The drain drives it as master; the consumer is the slave.
interface load_store_drain_if
  import load_store_drain_pkg::*;
#(
  parameter int CBITS = DEF_CBITS
) ();
  logic             valid;
  logic             ready;
  logic [CBITS-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );
endinterface

// File: rtl/load_store_drain_rise_detect.sv
// Registered rising-edge detector on the loader full indication.
// full_q clears on reset, so a level held high through reset counts as an edge.
module load_store_drain_rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o
);
  logic full_q;
  logic rise_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      full_q <= d_i;
      rise_q <= d_i && !full_q;
    end
  end

  assign rise_o = rise_q;
endmodule

// File: rtl/load_store_drain.sv
// Drains N units downstream per full edge, then pulses empty for one cycle.
// Edges arriving while busy only set the sticky overrun flag.
module load_store_drain
  import load_store_drain_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int CBITS = DEF_CBITS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      full_i,
  load_store_drain_if.master        dn,
  output logic                      busy_o,
  output logic                      empty_pulse_o,
  output logic                      overrun_o,
  output logic [7:0]                drain_cnt_o
);
  if (N < 0 || N > (2 ** CBITS) - 1) begin : g_bad_n
    $error("load_store_drain: N does not fit in CBITS");
  end

  localparam logic [CBITS-1:0] NV  = CBITS'(N);
  localparam logic [CBITS-1:0] ONE = CBITS'(1);

  drain_state_t     state_q, state_d;
  logic [CBITS-1:0] vol_q, vol_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             pulse_q, pulse_d;
  logic             ovr_q, ovr_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             rise;
  logic             beat;

  load_store_drain_rise_detect u_rise (
    .clk    (clk),
    .rst    (rst),
    .d_i    (full_i),
    .rise_o (rise)
  );

  assign beat = valid_q && dn.ready;

  always_comb begin
    state_d = state_q;
    vol_d   = vol_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    pulse_d = 1'b0;
    ovr_d   = ovr_q;
    cnt_d   = cnt_q;
    if (rise && state_q != S_IDLE) ovr_d = 1'b1;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (rise) begin
          vol_d  = NV;
          busy_d = 1'b1;
          if (N == 0) begin
            state_d = S_DONE;
            pulse_d = 1'b1;
            cnt_d   = cnt_q + 8'd1;
          end else begin
            state_d = S_DRAIN;
            valid_d = 1'b1;
          end
        end
      end
      (state_q == S_DRAIN): begin
        if (beat) begin
          vol_d = vol_q - ONE;
          // last unit leaves on this edge
          if (vol_q == ONE) begin
            state_d = S_DONE;
            valid_d = 1'b0;
            pulse_d = 1'b1;
            cnt_d   = cnt_q + 8'd1;
          end
        end
      end
      (state_q == S_DONE): begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      vol_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      pulse_q <= 1'b0;
      ovr_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      vol_q   <= vol_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      pulse_q <= pulse_d;
      ovr_q   <= ovr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dn.valid      = valid_q;
  assign dn.data       = vol_q;
  assign busy_o        = busy_q;
  assign empty_pulse_o = pulse_q;
  assign overrun_o     = ovr_q;
  assign drain_cnt_o   = cnt_q;

  p_stable: assert property (@(posedge clk) disable iff (rst)
    dn.valid && !dn.ready |=> dn.valid && $stable(dn.data));

  p_bound: assert property (@(posedge clk) disable iff (rst)
    dn.valid |-> (dn.data != '0 && dn.data <= NV));

`ifdef FORMAL
  a_ready: assume property (@(posedge clk) s_eventually dn.ready);
  a_full:  assume property (@(posedge clk)
    s_eventually (full_i && !$past(full_i)));
  p_live:  assert property (@(posedge clk)
    s_eventually (rst || empty_pulse_o));
`endif
endmodule

// File: tb/tb_load_store_drain.sv
// Directed-plus-random bench for load_store_drain (N=5 and N=0 builds).
// Expected beats, pulse counts and drain counts come from a transaction model.
module tb_load_store_drain;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, full_i, busy, pulse, ovr;
  logic [7:0] cnt;
  logic       rst_z, full_z, busy_z, pulse_z, ovr_z;
  logic [7:0] cnt_z;

  load_store_drain_if #(.CBITS(3)) ifa ();
  load_store_drain_if #(.CBITS(3)) ifz ();

  load_store_drain #(.N(5), .CBITS(3)) u_dut (
    .clk           (clk),
    .rst           (rst),
    .full_i        (full_i),
    .dn            (ifa),
    .busy_o        (busy),
    .empty_pulse_o (pulse),
    .overrun_o     (ovr),
    .drain_cnt_o   (cnt)
  );

  load_store_drain #(.N(0), .CBITS(3)) u_dut_z (
    .clk           (clk),
    .rst           (rst_z),
    .full_i        (full_z),
    .dn            (ifz),
    .busy_o        (busy_z),
    .empty_pulse_o (pulse_z),
    .overrun_o     (ovr_z),
    .drain_cnt_o   (cnt_z)
  );

  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         pulses = 0;
  int         last_beat = -100;
  int         gap = -1;
  int         exp_cnt = 0;
  int         p0;
  bit         rand_ready = 1'b0;
  bit         z_valid_seen = 1'b0;
  logic [2:0] beats[$];

  always @(posedge clk)
    if (ifz.valid === 1'b1) z_valid_seen <= 1'b1;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic v, r, rs;
    logic [2:0] d;
    if (rand_ready) ifa.ready = ($urandom_range(0, 3) != 0);
    v  = ifa.valid;
    r  = ifa.ready;
    d  = ifa.data;
    rs = rst;
    @(posedge clk);
    #1;
    cyc++;
    if (rs) begin
      beats.delete();
    end else begin
      if (v && r) begin
        beats.push_back(d);
        last_beat = cyc - 1;
      end
      if (v && !r) begin
        check("stall_valid", ifa.valid, 1);
        check("stall_data", ifa.data, d);
      end
      if (pulse) begin
        pulses++;
        gap = cyc - last_beat;
      end
    end
  endtask

  task automatic check_beats(input string tag);
    check({tag, "_nbeats"}, beats.size(), 5);
    foreach (beats[i]) check({tag, "_beat"}, beats[i], 5 - i);
    beats.delete();
  endtask

  task automatic drain_wait(input string tag);
    int s;
    s = pulses;
    for (int k = 0; k < 200 && pulses == s; k++) tick();
    check({tag, "_done"}, pulses - s, 1);
    check({tag, "_gap"}, gap, 1);
    exp_cnt = (exp_cnt + 1) % 256;
    check({tag, "_cnt"}, cnt, exp_cnt);
  endtask

  task automatic wait_data(input logic [2:0] dv, input string tag);
    for (int k = 0; k < 50 && !(ifa.valid && ifa.data == dv); k++) tick();
    check({tag, "_valid"}, ifa.valid, 1);
    check({tag, "_data"}, ifa.data, dv);
  endtask

  initial begin
    rst = 1'b1;
    full_i = 1'b0;
    ifa.ready = 1'b1;
    rst_z = 1'b1;
    full_z = 1'b0;
    ifz.ready = 1'b1;
    tick();
    tick();
    check("rst_valid", ifa.valid, 0);
    check("rst_data", ifa.data, 0);
    check("rst_busy", busy, 0);
    check("rst_pulse", pulse, 0);
    check("rst_ovr", ovr, 0);
    check("rst_cnt", cnt, 0);
    check("rst_z_pulse", pulse_z, 0);

    // N=0: edge sampled, then pulse on the following cycle only
    rst_z = 1'b0;
    full_z = 1'b1;
    tick();
    check("z_pulse_t0", pulse_z, 0);
    tick();
    check("z_pulse_t1", pulse_z, 1);
    check("z_busy_t1", busy_z, 1);
    check("z_cnt_t1", cnt_z, 1);
    tick();
    check("z_pulse_t2", pulse_z, 0);
    check("z_busy_t2", busy_z, 0);
    repeat (3) tick();
    check("z_held_cnt", cnt_z, 1);
    full_z = 1'b0;
    tick();
    full_z = 1'b1;
    tick();
    tick();
    check("z_pulse2", pulse_z, 1);
    check("z_cnt2", cnt_z, 2);
    tick();
    check("z_never_valid", z_valid_seen, 0);

    // 1: basic drain with ready held high
    rst = 1'b0;
    full_i = 1'b1;
    tick();
    check("t1_lat0", ifa.valid, 0);
    tick();
    check("t1_lat1_valid", ifa.valid, 1);
    check("t1_lat1_data", ifa.data, 5);
    check("t1_busy", busy, 1);
    drain_wait("t1");
    check_beats("t1");
    check("t1_ovr", ovr, 0);
    tick();
    check("t1_pulse_off", pulse, 0);
    check("t1_idle", busy, 0);

    // 2: stall three cycles at data 3
    full_i = 1'b0;
    tick();
    full_i = 1'b1;
    wait_data(3, "t2_at3");
    ifa.ready = 1'b0;
    repeat (3) tick();
    check("t2_stall_valid", ifa.valid, 1);
    check("t2_stall_data", ifa.data, 3);
    ifa.ready = 1'b1;
    drain_wait("t2");
    check_beats("t2");
    tick();

    // 3: second edge during drain sets overrun, no restart
    full_i = 1'b0;
    tick();
    full_i = 1'b1;
    rand_ready = 1'b1;
    p0 = pulses;
    tick();
    tick();
    full_i = 1'b0;
    tick();
    full_i = 1'b1;
    tick();
    tick();
    check("t3_ovr", ovr, 1);
    drain_wait("t3");
    rand_ready = 1'b0;
    ifa.ready = 1'b1;
    check_beats("t3");
    repeat (6) tick();
    check("t3_one_pulse", pulses - p0, 1);
    check("t3_no_restart", ifa.valid, 0);
    check("t3_ovr_sticky", ovr, 1);

    // edge landing in the DONE cycle is an overrun, not a new drain
    rst = 1'b1;
    full_i = 1'b0;
    tick();
    rst = 1'b0;
    exp_cnt = 0;
    check("rst2_ovr", ovr, 0);
    check("rst2_cnt", cnt, 0);
    full_i = 1'b1;
    tick();
    full_i = 1'b0;
    wait_data(1, "t7_at1");
    full_i = 1'b1;
    p0 = pulses;
    tick();
    exp_cnt = 1;
    check("t7_pulse", pulse, 1);
    check("t7_cnt", cnt, exp_cnt);
    tick();
    check("t7_ovr", ovr, 1);
    check("t7_busy", busy, 0);
    repeat (4) tick();
    check("t7_no_drain", ifa.valid, 0);
    check("t7_one_pulse", pulses - p0, 1);
    check_beats("t7");

    // 4: reset mid-drain abandons; held full restarts afterwards
    full_i = 1'b0;
    tick();
    full_i = 1'b1;
    wait_data(2, "t4_at2");
    rst = 1'b1;
    p0 = pulses;
    tick();
    exp_cnt = 0;
    check("t4_valid", ifa.valid, 0);
    check("t4_busy", busy, 0);
    check("t4_pulse", pulse, 0);
    check("t4_cnt", cnt, 0);
    check("t4_ovr", ovr, 0);
    check("t4_data", ifa.data, 0);
    rst = 1'b0;
    tick();
    check("t4_lat0", ifa.valid, 0);
    check("t4_no_pulse", pulses - p0, 0);
    tick();
    check("t4_restart_valid", ifa.valid, 1);
    check("t4_restart_data", ifa.data, 5);
    drain_wait("t4");
    check_beats("t4");
    tick();

    // random ready and random idle gaps
    rand_ready = 1'b1;
    repeat (8) begin
      full_i = 1'b0;
      repeat ($urandom_range(1, 3)) tick();
      full_i = 1'b1;
      drain_wait("rnd");
      check_beats("rnd");
      tick();
    end
    rand_ready = 1'b0;
    ifa.ready = 1'b1;

    // 6: 256 back-to-back drains wrap the counter
    rst = 1'b1;
    full_i = 1'b0;
    tick();
    rst = 1'b0;
    exp_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      full_i = 1'b0;
      tick();
      full_i = 1'b1;
      drain_wait("t6");
      check_beats("t6");
      tick();
    end
    check("t6_wrap", cnt, 0);
    check("t6_ovr", ovr, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
